// File: rtl/edp_pkg.sv
// Shared definitions for the exact-dot-product complete register datapath:
// register geometry helpers, FP32 field constants and the normalizer FSM states.
package edp_pkg;

  localparam int FP32_EXP_W   = 32'sd8;
  localparam int FP32_MAN_W   = 32'sd23;
  localparam int FP32_PREC    = 32'sd24;   // hidden one plus stored mantissa
  localparam int FP32_BIAS    = 32'sd127;
  localparam int FP32_EXP_MAX = 32'sd255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } normalizer_state_t;

  // Total magnitude width of the complete register.
  function automatic int complete_register_size(input int words, input int word_size);
    return words * word_size;
  endfunction

  // Bit position of the binary point; bit ZERO_POINT-1 carries weight 1.0.
  function automatic int zero_point(input int size);
    return size / 32'sd2;
  endfunction

  // Words kept after the leading word: enough to always hold 24 significant bits
  // plus guard, whatever bit of the leading word the leading one sits in.
  function automatic int window_words(input int word_size);
    return 32'sd1 + (FP32_PREC + word_size - 32'sd1) / word_size;
  endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// Combinational round-to-nearest-even and FP32 packing of the captured window.
// The window is left-aligned: its top word is the leading nonzero word of the
// register, whose index is i_lead_idx; everything below the window is in i_sticky.
module fp32_round_pack
  import edp_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int WIN_BITS   = 32,
  parameter int IDX_W      = 7,
  parameter int ZERO_POINT = 512
) (
  input  logic [WIN_BITS-1:0] i_window,
  input  logic                i_sticky,
  input  logic [IDX_W-1:0]    i_lead_idx,
  input  logic                i_sign,
  input  logic                i_zero,
  output logic [31:0]         o_out,
  output logic                o_overflow,
  output logic                o_underflow,
  output logic                o_inexact
);

  localparam int POS_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

  logic [WORD_SIZE-1:0]  w_top;
  logic [POS_W-1:0]      w_lead_pos;
  logic [WIN_BITS-1:0]   w_norm;
  logic [FP32_MAN_W-1:0] w_man;
  logic [FP32_MAN_W-1:0] w_man_rnd;
  logic                  w_guard;
  logic                  w_sticky;
  logic                  w_round_up;
  logic                  w_carry;
  int                    w_exp_pre;
  int                    w_exp_post;

  assign w_top = i_window[WIN_BITS-1 -: WORD_SIZE];

  // Position of the most significant one inside the leading word.
  always_comb begin
    w_lead_pos = '0;
    for (int b = 0; b < WORD_SIZE; b++) begin
      w_lead_pos = w_top[b] ? POS_W'(b) : w_lead_pos;
    end
  end

  // Move the leading one to the window MSB; below it lie mantissa, guard, rest.
  assign w_norm     = i_window << (WORD_SIZE - 1 - int'(w_lead_pos));
  assign w_man      = w_norm[WIN_BITS-2 -: FP32_MAN_W];
  assign w_guard    = w_norm[WIN_BITS-1-FP32_PREC];
  assign w_sticky   = i_sticky | (|(w_norm << (FP32_PREC + 1)));
  assign w_round_up = w_guard & (w_sticky | w_man[0]);

  // A carry out leaves the mantissa field at zero, i.e. the next power of two.
  assign {w_carry, w_man_rnd} = {1'b0, w_man} + {{FP32_MAN_W{1'b0}}, w_round_up};

  assign w_exp_pre  = int'(i_lead_idx) * WORD_SIZE + int'(w_lead_pos)
                      + (FP32_BIAS + 32'sd1) - ZERO_POINT;
  assign w_exp_post = w_exp_pre + int'(w_carry);

  // Select the special encodings or the rounded normal result.
  always_comb begin
    o_out       = 32'h0000_0000;
    o_overflow  = 1'b0;
    o_underflow = 1'b0;
    o_inexact   = 1'b0;
    if (i_zero) begin
      o_out = 32'h0000_0000;
    end else if (w_exp_pre <= 32'sd0) begin
      o_out       = {i_sign, 31'd0};
      o_underflow = 1'b1;
      o_inexact   = 1'b1;
    end else if (w_exp_post >= FP32_EXP_MAX) begin
      o_out      = {i_sign, 8'hFF, 23'd0};
      o_overflow = 1'b1;
      o_inexact  = 1'b1;
    end else begin
      o_out     = {i_sign, w_exp_post[FP32_EXP_W-1:0], w_man_rnd};
      o_inexact = w_guard | w_sticky;
    end
  end

endmodule

// File: rtl/complete_register_normalizer.sv
// Word-serial conversion of the complete register (magnitude + sign) to FP32.
// The register is scanned from the most significant word down, one word per
// cycle; the first nonzero word and the words after it fill a small window,
// later words only contribute to sticky. Latency is fixed at WORDS+2 cycles.
module complete_register_normalizer
  import edp_pkg::*;
#(
  parameter int COMPLETE_REGISTER_WORDS = 128,
  parameter int WORD_SIZE               = 8
) (
  input  logic                                         Clk,
  input  logic                                         Rst,
  input  logic                                         In_Valid,
  output logic                                         In_Ready,
  input  logic [COMPLETE_REGISTER_WORDS*WORD_SIZE-1:0] In_Register,
  input  logic                                         In_Sign,
  output logic                                         Out_Valid,
  input  logic                                         Out_Ready,
  output logic [31:0]                                  Out,
  output logic                                         Overflow,
  output logic                                         Underflow,
  output logic                                         Inexact
);

  localparam int SIZE      = complete_register_size(COMPLETE_REGISTER_WORDS, WORD_SIZE);
  localparam int ZP        = zero_point(SIZE);
  localparam int WIN_WORDS = window_words(WORD_SIZE);
  localparam int WIN_BITS  = WIN_WORDS * WORD_SIZE;
  localparam int IDX_W     = (COMPLETE_REGISTER_WORDS > 1) ? $clog2(COMPLETE_REGISTER_WORDS) : 1;
  localparam int WCNT_W    = $clog2(WIN_WORDS + 1);

  normalizer_state_t   r_state;
  logic [SIZE-1:0]     r_shadow;
  logic                r_sign;
  logic [IDX_W-1:0]    r_cnt;
  logic                r_found;
  logic [IDX_W-1:0]    r_lead_idx;
  logic [WIN_BITS-1:0] r_window;
  logic [WCNT_W-1:0]   r_win_cnt;
  logic                r_sticky;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [31:0]         r_out;
  logic                r_overflow;
  logic                r_underflow;
  logic                r_inexact;

  logic [WORD_SIZE-1:0] w_word;
  logic [WIN_BITS-1:0]  w_word_top;
  logic [WIN_BITS-1:0]  w_ins;
  logic                 w_win_full;
  logic [31:0]          w_out;
  logic                 w_overflow;
  logic                 w_underflow;
  logic                 w_inexact;

  // The shadow shifts up each scan cycle, so the word under examination is
  // always its top word and its index equals r_cnt.
  assign w_word     = r_shadow[SIZE-1 -: WORD_SIZE];
  assign w_word_top = {w_word, {(WIN_BITS-WORD_SIZE){1'b0}}};
  // The window stays left-aligned: unfilled low words are already zero padding.
  assign w_ins      = w_word_top >> (int'(r_win_cnt) * WORD_SIZE);
  assign w_win_full = (r_win_cnt == WCNT_W'(WIN_WORDS));

  fp32_round_pack #(
    .WORD_SIZE  (WORD_SIZE),
    .WIN_BITS   (WIN_BITS),
    .IDX_W      (IDX_W),
    .ZERO_POINT (ZP)
  ) u_round_pack (
    .i_window    (r_window),
    .i_sticky    (r_sticky),
    .i_lead_idx  (r_lead_idx),
    .i_sign      (r_sign),
    .i_zero      (~r_found),
    .o_out       (w_out),
    .o_overflow  (w_overflow),
    .o_underflow (w_underflow),
    .o_inexact   (w_inexact)
  );

  // Conversion FSM: capture, word-serial scan, round/pack register, hold result.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_shadow    <= '0;
      r_sign      <= 1'b0;
      r_cnt       <= '0;
      r_found     <= 1'b0;
      r_lead_idx  <= '0;
      r_window    <= '0;
      r_win_cnt   <= '0;
      r_sticky    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out       <= 32'h0000_0000;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_inexact   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (In_Valid) begin
            r_shadow   <= In_Register;
            r_sign     <= In_Sign;
            r_cnt      <= IDX_W'(COMPLETE_REGISTER_WORDS - 1);
            r_found    <= 1'b0;
            r_lead_idx <= '0;
            r_window   <= '0;
            r_win_cnt  <= '0;
            r_sticky   <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= SCAN;
          end
        end
        SCAN: begin
          r_shadow <= r_shadow << WORD_SIZE;
          if (!r_found) begin
            if (|w_word) begin
              r_found    <= 1'b1;
              r_lead_idx <= r_cnt;
              r_window   <= w_word_top;
              r_win_cnt  <= WCNT_W'(1);
            end
          end else if (!w_win_full) begin
            r_window  <= r_window | w_ins;
            r_win_cnt <= r_win_cnt + WCNT_W'(1);
          end else begin
            r_sticky <= r_sticky | (|w_word);
          end
          if (r_cnt == '0) begin
            r_state <= ROUND;
          end else begin
            r_cnt <= r_cnt - IDX_W'(1);
          end
        end
        ROUND: begin
          r_out       <= w_out;
          r_overflow  <= w_overflow;
          r_underflow <= w_underflow;
          r_inexact   <= w_inexact;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (Out_Ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign In_Ready  = r_in_ready;
  assign Out_Valid = r_out_valid;
  assign Out       = r_out;
  assign Overflow  = r_overflow;
  assign Underflow = r_underflow;
  assign Inexact   = r_inexact;

endmodule

// File: doc/complete_register_normalizer.md
# complete_register_normalizer

Sequential converter from the exact-dot-product complete register (a wide fixed-point magnitude plus sign) back to an IEEE-754 single-precision value with round-to-nearest-even. It sits downstream of the exact multiply-accumulator datapath and replaces a full-width leading-zero detector with a word-serial scan, trading latency for area. It uses valid/ready handshakes on both sides.

## Interface
- `COMPLETE_REGISTER_WORDS`, default 128: number of words in the complete register.
- `WORD_SIZE`, default 8: bits per word; the scan processes one word per cycle.
- `Clk`  in  1: the single clock.
- `Rst`  in  1: synchronous, active-high reset.
- `In_Valid`  in  1: input request.
- `In_Ready`  out  1: block can accept; high only in IDLE.
- `In_Register`  in  WORDS*WORD_SIZE: unsigned magnitude.
- `In_Sign`  in  1: sign of the value.
- `Out_Valid`  out  1: result available.
- `Out_Ready`  in  1: consumer accepts the result.
- `Out`  out  32: FP32 result.
- `Overflow`, `Underflow`, `Inexact`  out  1 each: status flags, valid with `Out_Valid`.

## Operation
- Derived quantities: SIZE = WORDS*WORD_SIZE; ZERO_POINT = SIZE/2; WINDOW_WORDS = 1 + ceil(24/WORD_SIZE), which is 4 at the defaults.
- Value convention: a leading one at bit p gives biased exponent E = p + 128 − ZERO_POINT. For example, bit ZERO_POINT−1 represents 1.0.
- States are IDLE, SCAN, ROUND and DONE.
- **IDLE**
  - On `In_Valid`, copy `In_Register` and `In_Sign` into a shadow register, reset the word counter to WORDS−1, and go to SCAN.
- **SCAN** (exactly WORDS cycles), examining word i = counter each cycle:
  - No leading word found yet and word is nonzero: record the leading word index w and load the word into the window.
  - Leading word already found and the window is not full: shift the word into the window.
  - Window full: OR the word into sticky.
  - If the scan ends with the window unfilled, pad the window with zeros.
  - Go to ROUND after counter 0.
- **ROUND** (1 cycle):
  - Locate the leading one inside the top window word.
  - mantissa = next 23 bits; G = following bit; S = sticky OR all remaining window bits.
  - Round to nearest even: increment when G & (S | mantissa LSB).
  - If rounding carries out of the mantissa, set mantissa to 0 and E+1.
  - Register `Out` and the flags, then go to DONE.
- **DONE**
  - Hold `Out_Valid`=1 with `Out` and flags stable.
  - On `Out_Ready`, go to IDLE.
- Special results:
  - All-zero register: `Out`=0x00000000 regardless of sign; all flags 0.
  - E (after rounding) ≥ 255: `Out` = {sign, 8'hFF, 23'b0}; Overflow=1, Inexact=1.
  - E ≤ 0 (before rounding): flush to {sign, 31'b0}; Underflow=1, Inexact=1. Subnormals are not produced.
  - Otherwise Inexact = G | S.

## Timing
- Reset values: state IDLE; `In_Ready`=1; `Out_Valid`=0; `Out`=0; all flags 0; shadow, window and sticky cleared.
- Latency is fixed and independent of data. If the accept happens in cycle k, `Out_Valid` rises in cycle k+WORDS+2, which is cycle k+130 at the defaults.
- `In_Ready` is 0 from k+1 until the cycle after the output handshake.
- Throughput is at most one conversion per WORDS+3 cycles.
- `Out_Ready` asserted before `Out_Valid` has no effect. Back-pressure holds DONE indefinitely.
- `Rst` mid-operation, in any state, aborts the conversion next edge. No partial result is emitted and there is no `Out_Valid` pulse.
- `In_Valid` while busy is ignored and not queued.

## Structure
- Package `edp_pkg` holds:
  - `COMPLETE_REGISTER_SIZE`, `ZERO_POINT` and `WINDOW_WORDS` functions/localparams;
  - FP32 field widths, `FP32_BIAS`=127 and `FP32_EXP_MAX`=255;
  - the `normalizer_state_t` enum {IDLE, SCAN, ROUND, DONE}.
- Sub-module `fp32_round_pack` is combinational. It takes the window, sticky, w, sign and zero flag, and produces `Out` plus the three flags. It is instantiated ahead of the ROUND-stage register.

## Test plan
All scenarios use default parameters (E = p − 384).
- Bit 511 set, `In_Sign`=0 → 0x3F800000, no flags, `Out_Valid` exactly 130 cycles after accept.
- Bits 511 and 510, `In_Sign`=1 → 0xBFC00000.
- Tie cases:
  - Bits 511 and 487 → ties-to-even → 0x3F800000, Inexact=1.
  - Add bit 488 → 0x3F800002.
  - Bits 511, 487 and 0 → sticky forces round-up → 0x3F800001.
- Overflow and underflow:
  - Bit 1023 → 0x7F800000, Overflow=1.
  - Bit 384 → 0x00000000, Underflow=1.
  - Bit 385 → 0x00800000, no flags.
- Handshake and reset:
  - All-zero register with `In_Sign`=1 → 0x00000000.
  - `Out_Ready` low for 10 cycles → `Out` held, `In_Ready`=0.
  - `Rst` at SCAN cycle 50 → back in IDLE next cycle, no `Out_Valid`.
